// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port unified memory between the instruction-fetch port and the
// data port, sequencing each granted access over a fixed memory latency.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    typedef enum logic {
        GRANT_IF,
        GRANT_D
    } grant_t;

    state_t            state, state_n;
    grant_t            last_grant;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              cmd_we;
    logic [DATA_W-1:0] if_hold, d_hold;
    logic              data_pend, busy, first_cycle, last_cycle;
    logic              latch_if, latch_d;

    assign data_pend   = d_rd | d_wr;
    assign busy        = (state != IDLE);
    assign first_cycle = busy && (cnt == CNT_W'(1));
    assign last_cycle  = busy && (cnt == CNT_W'(MEM_LAT));

    // On a tie the port that was not served last wins, so contention alternates.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        latch_if = 1'b0;
        latch_d  = 1'b0;
        case (state)
            IDLE: begin
                if (data_pend && (!if_req || last_grant == GRANT_IF)) begin
                    state_n = BUSY_D;
                    cnt_n   = CNT_W'(1);
                    latch_d = 1'b1;
                end else if (if_req) begin
                    state_n  = BUSY_I;
                    cnt_n    = CNT_W'(1);
                    latch_if = 1'b1;
                end
            end
            BUSY_I, BUSY_D: begin
                if (last_cycle) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= GRANT_IF;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_we     <= 1'b0;
            if_hold    <= '0;
            d_hold     <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (latch_d) begin
                cmd_addr  <= d_addr;
                cmd_wdata <= d_wdata;
                cmd_we    <= d_wr;
            end else if (latch_if) begin
                cmd_addr <= if_addr;
                cmd_we   <= 1'b0;
            end
            if (last_cycle) begin
                last_grant <= (state == BUSY_D) ? GRANT_D : GRANT_IF;
                if (state == BUSY_I) begin
                    if_hold <= mem_rdata;
                end else if (!cmd_we) begin
                    d_hold <= mem_rdata;
                end
            end
        end
    end

    // Read data is passed through in the ready cycle and held afterwards.
    always_comb begin
        mem_en    = first_cycle;
        mem_we    = first_cycle & cmd_we;
        mem_addr  = cmd_addr;
        mem_wdata = cmd_wdata;
        if_ready  = last_cycle && (state == BUSY_I);
        d_ready   = last_cycle && (state == BUSY_D);
        if_rdata  = if_ready ? mem_rdata : if_hold;
        d_rdata   = (d_ready && !cmd_we) ? mem_rdata : d_hold;
        if_stall  = if_req & ~if_ready;
        d_stall   = data_pend & ~d_ready;
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: requesters push expected completions,
// a negedge monitor pops and compares them whenever a ready pulse appears.
module tb_unified_mem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready, if_stall;
    logic        d_rd = 1'b0;
    logic        d_wr = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready, d_stall;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_stall(if_stall),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: read data is addr ^ 0x8C221004 unless the address was last written,
    // and is only valid in the MEM_LAT-th cycle of an access.
    int          phase;
    logic        wr_valid;
    logic [31:0] wr_addr, wr_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= 0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            if (mem_en) phase <= 2;
            else if (phase != 0 && phase < 8) phase <= phase + 1;
            if (mem_en && mem_we) begin
                wr_valid <= 1'b1;
                wr_addr  <= mem_addr;
                wr_data  <= mem_wdata;
            end
        end
    end

    always_comb begin
        mem_rdata = 32'hBAD0BAD0;
        if ((mem_en ? 1 : phase) == LAT) begin
            if (wr_valid && mem_addr == wr_addr) mem_rdata = wr_data;
            else mem_rdata = mem_addr ^ 32'h8C221004;
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic        is_write;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];
    bit   ord_q[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          en_count = 0;
    int          en_cycle = 0;
    logic [31:0] en_addr = '0;
    logic        en_we = 1'b0;
    logic [31:0] en_wdata = '0;
    logic [31:0] exp_if_hold = '0;
    logic [31:0] exp_d_hold = '0;
    int          i_ready_cyc = 0;
    int          d_ready_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got timeout/unexpected event expected none", name);
    endtask

    task automatic push_fetch(input logic [31:0] addr, input logic [31:0] rdata);
        exp_t e;
        e.addr = addr; e.is_write = 1'b0; e.wdata = '0; e.rdata = rdata;
        iq.push_back(e);
    endtask

    task automatic push_data(input logic [31:0] addr, input logic we,
                             input logic [31:0] wdata, input logic [31:0] rdata);
        exp_t e;
        e.addr = addr; e.is_write = we; e.wdata = wdata; e.rdata = rdata;
        dq.push_back(e);
    endtask

    task automatic check_completion(input bit port);
        exp_t e;
        logic [31:0] rd;
        if (ord_q.size() == 0) begin
            fail_now("order_unexpected");
        end else begin
            check_val("grant_order", {31'b0, port}, {31'b0, ord_q.pop_front()});
        end
        if ((port ? dq.size() : iq.size()) == 0) begin
            fail_now(port ? "d_ready_unexpected" : "if_ready_unexpected");
            return;
        end
        e  = port ? dq.pop_front() : iq.pop_front();
        rd = port ? d_rdata : if_rdata;
        check_val(port ? "d_rdata" : "if_rdata", rd, e.rdata);
        check_val("mem_addr_held", mem_addr, e.addr);
        check_val("en_addr", en_addr, e.addr);
        check_val("en_we", {31'b0, en_we}, {31'b0, e.is_write});
        if (e.is_write) check_val("en_wdata", en_wdata, e.wdata);
        check_val("en_count", en_count, 1);
        check_val("en_to_ready", cyc - en_cycle, LAT - 1);
        if (port) begin
            exp_d_hold  = e.rdata;
            d_ready_cyc = cyc;
        end else begin
            exp_if_hold = e.rdata;
            i_ready_cyc = cyc;
        end
        en_count = 0;
    endtask

    // Monitor: stall/hold checks every cycle, scoreboard pop on each ready pulse.
    always @(negedge clk) begin
        if (rst) begin
            en_count    = 0;
            exp_if_hold = '0;
            exp_d_hold  = '0;
        end else begin
            check_val("if_stall", {31'b0, if_stall}, {31'b0, if_req & ~if_ready});
            check_val("d_stall", {31'b0, d_stall}, {31'b0, (d_rd | d_wr) & ~d_ready});
            if (!if_ready) check_val("if_hold", if_rdata, exp_if_hold);
            if (!d_ready) check_val("d_hold", d_rdata, exp_d_hold);
            if (mem_en) begin
                en_count++;
                en_cycle = cyc;
                en_addr  = mem_addr;
                en_we    = mem_we;
                en_wdata = mem_wdata;
            end
            if (if_ready && d_ready) fail_now("both_ready");
            if (if_ready) check_completion(1'b0);
            if (d_ready) check_completion(1'b1);
        end
    end

    // Requester models: called just after a rising edge, hold the request until ready,
    // drop it on the ready edge.
    task automatic apply_fetch(input logic [31:0] addr, input int min_w, input int max_w);
        int waited = 0;
        bit timed_out = 0;
        if_req  = 1'b1;
        if_addr = addr;
        forever begin
            @(negedge clk);
            if (if_ready) break;
            waited++;
            if (waited > 50) begin timed_out = 1; break; end
        end
        @(posedge clk); #1;
        if_req = 1'b0;
        if (timed_out) fail_now("fetch_timeout");
        else check_val("fetch_wait_in_range", {31'b0, (waited >= min_w && waited <= max_w)}, 32'd1);
    endtask

    task automatic apply_data(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input int min_w, input int max_w);
        int waited = 0;
        bit timed_out = 0;
        d_rd    = rd;
        d_wr    = wr;
        d_addr  = addr;
        d_wdata = wdata;
        forever begin
            @(negedge clk);
            if (d_ready) break;
            waited++;
            if (waited > 50) begin timed_out = 1; break; end
        end
        @(posedge clk); #1;
        d_rd = 1'b0;
        d_wr = 1'b0;
        if (timed_out) fail_now("data_timeout");
        else check_val("data_wait_in_range", {31'b0, (waited >= min_w && waited <= max_w)}, 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_mem_en"}, {31'b0, mem_en}, 32'd0);
        check_val({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
        check_val({tag, "_mem_addr"}, mem_addr, 32'd0);
        check_val({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check_val({tag, "_if_ready"}, {31'b0, if_ready}, 32'd0);
        check_val({tag, "_d_ready"}, {31'b0, d_ready}, 32'd0);
        check_val({tag, "_if_rdata"}, if_rdata, 32'd0);
        check_val({tag, "_d_rdata"}, d_rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Lone fetch.
        ord_q.push_back(1'b0);
        push_fetch(32'h1000, 32'h8C220004);
        apply_fetch(32'h1000, LAT, LAT);

        // Tie after a fetch: data first, fetch one access later.
        ord_q.push_back(1'b1);
        ord_q.push_back(1'b0);
        push_data(32'h2000, 1'b0, 32'h0, 32'h8C223004);
        push_fetch(32'h1004, 32'h8C220000);
        fork
            apply_data(1'b1, 1'b0, 32'h2000, 32'h0, LAT, LAT);
            apply_fetch(32'h1004, 2 * LAT + 1, 2 * LAT + 1);
        join
        check_val("tie_ready_spacing", i_ready_cyc - d_ready_cyc, LAT + 1);

        // Write leaves d_rdata unchanged, then read it back.
        ord_q.push_back(1'b1);
        push_data(32'h2004, 1'b1, 32'hDEADBEEF, 32'h8C223004);
        apply_data(1'b0, 1'b1, 32'h2004, 32'hDEADBEEF, LAT, LAT);
        ord_q.push_back(1'b1);
        push_data(32'h2004, 1'b0, 32'h0, 32'hDEADBEEF);
        apply_data(1'b1, 1'b0, 32'h2004, 32'h0, LAT, LAT);

        // Continuous contention: last grant was data, so fetch leads and they alternate.
        for (int k = 0; k < 3; k++) begin
            ord_q.push_back(1'b0);
            ord_q.push_back(1'b1);
        end
        push_fetch(32'h1008, 32'h8C22000C);
        push_fetch(32'h100C, 32'h8C220008);
        push_fetch(32'h1010, 32'h8C220014);
        push_data(32'h2008, 1'b0, 32'h0, 32'h8C22300C);
        push_data(32'h200C, 1'b0, 32'h0, 32'h8C223008);
        push_data(32'h2010, 1'b0, 32'h0, 32'h8C223014);
        fork
            begin
                apply_fetch(32'h1008, LAT, 2 * LAT + 1);
                apply_fetch(32'h100C, LAT, 2 * LAT + 1);
                apply_fetch(32'h1010, LAT, 2 * LAT + 1);
            end
            begin
                apply_data(1'b1, 1'b0, 32'h2008, 32'h0, LAT, 2 * LAT + 1);
                apply_data(1'b1, 1'b0, 32'h200C, 32'h0, LAT, 2 * LAT + 1);
                apply_data(1'b1, 1'b0, 32'h2010, 32'h0, LAT, 2 * LAT + 1);
            end
        join

        // Read and write together behave as a write.
        ord_q.push_back(1'b1);
        push_data(32'h2010, 1'b1, 32'h12345678, 32'h8C223014);
        apply_data(1'b1, 1'b1, 32'h2010, 32'h12345678, LAT, LAT);
        ord_q.push_back(1'b1);
        push_data(32'h2010, 1'b0, 32'h0, 32'h12345678);
        apply_data(1'b1, 1'b0, 32'h2010, 32'h0, LAT, LAT);

        // Reset in the command cycle of a data read discards the access.
        d_rd   = 1'b1;
        d_addr = 32'h2000;
        waited = 0;
        forever begin
            @(negedge clk);
            if (mem_en) break;
            waited++;
            if (waited > 20) break;
        end
        if (waited > 20) fail_now("reset_test_no_mem_en");
        rst = 1'b1;
        #1;
        check_outputs_zero("mid_reset");
        d_rd = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        ord_q.push_back(1'b0);
        push_fetch(32'h1000, 32'h8C220004);
        apply_fetch(32'h1000, LAT, LAT);

        repeat (3) @(posedge clk);
        check_val("iq_drained", iq.size(), 0);
        check_val("dq_drained", dq.size(), 0);
        check_val("order_drained", ord_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
